// File: rtl/tag_lookup_pkg.sv
// Shared encodings for the L2 tag lookup block: request opcodes and FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package tag_lookup_pkg;

   // Request opcodes carried on reqOp
   localparam logic [1:0] OP_LOOKUP   = 2'b00;
   localparam logic [1:0] OP_WRLOOKUP = 2'b01;
   localparam logic [1:0] OP_FILL     = 2'b10;
   localparam logic [1:0] OP_INVAL    = 2'b11;

   // Controller states: INIT sweeps the arrays, READY accepts requests
   localparam logic [0:0] ST_INIT  = 1'b0;
   localparam logic [0:0] ST_READY = 1'b1;

endpackage

// File: rtl/tag_lookup_lru_if.sv
// Request/response bundle between the request decoder and the tag lookup block.
// Latency: response one cycle after an accepted request.
// Backpressure: reqReady gates requests; responses cannot be stalled.
// Ports: master drives the request and observes the response; slave is the tag store.
interface tag_lookup_lru_if #(
   parameter int ways      = 8,
   parameter int tagBits   = 10,
   parameter int indexBits = 6
);
   localparam int wayBits = $clog2(ways);

   logic                 reqValid;
   logic                 reqReady;
   logic [1:0]           reqOp;
   logic [indexBits-1:0] reqIndex;
   logic [tagBits-1:0]   reqTag;

   logic                 respValid;
   logic                 respHit;
   logic [wayBits-1:0]   respWay;
   logic                 respVictimValid;
   logic [tagBits-1:0]   respVictimTag;
   logic                 respDirty;
   logic                 respMulti;

   modport master (
      output reqValid, reqOp, reqIndex, reqTag,
      input  reqReady, respValid, respHit, respWay, respVictimValid,
             respVictimTag, respDirty, respMulti
   );

   modport slave (
      input  reqValid, reqOp, reqIndex, reqTag,
      output reqReady, respValid, respHit, respWay, respVictimValid,
             respVictimTag, respDirty, respMulti
   );
endinterface

// File: rtl/tag_lookup_lru_way_matcher.sv
// Tag compare across all ways of one set: hit, multi-hit, lowest hit way, lowest invalid way.
// Latency: combinational.
// Backpressure: none.
// Ports: tags/valid of the set and the request tag in; match summary out.
module way_matcher #(
   parameter int ways    = 8,
   parameter int tagBits = 10
) (
   input  logic [ways-1:0][tagBits-1:0] tags,
   input  logic [ways-1:0]              valid,
   input  logic [tagBits-1:0]           tag,
   output logic                         hit,
   output logic                         multi,
   output logic [$clog2(ways)-1:0]      hit_way,
   output logic [$clog2(ways)-1:0]      inv_way,
   output logic                         all_valid
);
   localparam int wayBits = $clog2(ways);

   // Scan from the top way down so the lowest index is the last assignment and wins.
   always_comb begin
      hit       = 1'b0;
      multi     = 1'b0;
      hit_way   = '0;
      inv_way   = '0;
      all_valid = 1'b1;
      for (int w = ways - 1; w >= 0; w--) begin
         if (valid[w] && (tags[w] == tag)) begin
            if (hit) multi = 1'b1;
            hit     = 1'b1;
            hit_way = wayBits'(w);
         end
         if (!valid[w]) begin
            all_valid = 1'b0;
            inv_way   = wayBits'(w);
         end
      end
   end
endmodule

// File: rtl/tag_lookup_lru.sv
// Set-associative tag store with valid/dirty bits and true-LRU replacement for the L2 model.
// Latency: 1 cycle, one request per cycle; arrays updated on the accepting edge.
// Backpressure: reqReady low only during the post-reset init sweep; no response stall.
// Ports: clock, reset (sync, active-high), bus (slave side of tag_lookup_lru_if).
module tag_lookup_lru
   import tag_lookup_pkg::*;
#(
   parameter int ways      = 8,
   parameter int tagBits   = 10,
   parameter int indexBits = 6
) (
   input  logic           clock,
   input  logic           reset,
   tag_lookup_lru_if.slave bus
);
   localparam int wayBits = $clog2(ways);
   localparam int sets    = 2 ** indexBits;

   // Non-resettable arrays; only the INIT sweep gives them defined contents.
   logic [ways-1:0][tagBits-1:0] tag_mem   [sets];
   logic [ways-1:0]              valid_mem [sets];
   logic [ways-1:0]              dirty_mem [sets];
   logic [ways-1:0][wayBits-1:0] age_mem   [sets];

   logic [0:0]           state;
   logic [indexBits-1:0] sweep_cnt;

   logic [ways-1:0][tagBits-1:0] cur_tag, nxt_tag;
   logic [ways-1:0]              cur_valid, nxt_valid, cur_dirty, nxt_dirty;
   logic [ways-1:0][wayBits-1:0] cur_age, nxt_age, init_age;

   logic               hit, multi, all_valid, accept, fill_miss, touch_en;
   logic [wayBits-1:0] hit_way, inv_way, lru_way, victim, sel_way;

   assign bus.reqReady = (state == ST_READY);
   assign accept       = bus.reqValid && (state == ST_READY);

   assign cur_tag   = tag_mem[bus.reqIndex];
   assign cur_valid = valid_mem[bus.reqIndex];
   assign cur_dirty = dirty_mem[bus.reqIndex];
   assign cur_age   = age_mem[bus.reqIndex];

   way_matcher #(.ways(ways), .tagBits(tagBits)) u_match (
      .tags      (cur_tag),
      .valid     (cur_valid),
      .tag       (bus.reqTag),
      .hit       (hit),
      .multi     (multi),
      .hit_way   (hit_way),
      .inv_way   (inv_way),
      .all_valid (all_valid)
   );

   // Invalid ways are always preferred; otherwise evict the oldest way.
   always_comb begin
      lru_way = '0;
      for (int w = 0; w < ways; w++)
         if (cur_age[w] == wayBits'(ways - 1)) lru_way = wayBits'(w);
   end

   assign victim    = all_valid ? lru_way : inv_way;
   assign sel_way   = hit ? hit_way : victim;
   assign fill_miss = (bus.reqOp == OP_FILL) && !hit;
   // Any hit except invalidate refreshes recency; a fill miss refreshes the new line.
   assign touch_en  = (hit && (bus.reqOp != OP_INVAL)) || fill_miss;

   always_comb begin
      nxt_age = cur_age;
      if (touch_en) begin
         for (int w = 0; w < ways; w++) begin
            if (wayBits'(w) == sel_way)
               nxt_age[w] = '0;
            else if (cur_age[w] < cur_age[sel_way])
               nxt_age[w] = cur_age[w] + 1'b1;
         end
      end
   end

   always_comb begin
      nxt_tag   = cur_tag;
      nxt_valid = cur_valid;
      nxt_dirty = cur_dirty;
      case (bus.reqOp)
         OP_WRLOOKUP: if (hit) nxt_dirty[hit_way] = 1'b1;
         OP_FILL: if (!hit) begin
            nxt_tag[victim]   = bus.reqTag;
            nxt_valid[victim] = 1'b1;
            nxt_dirty[victim] = 1'b0;
         end
         OP_INVAL: if (hit) begin
            nxt_valid[hit_way] = 1'b0;
            nxt_dirty[hit_way] = 1'b0;
         end
         default: ;
      endcase
   end

   always_comb begin
      for (int w = 0; w < ways; w++) init_age[w] = wayBits'(w);
   end

   // Array writes are suppressed in a reset cycle so a request racing reset leaves no trace.
   always_ff @(posedge clock) begin
      if (!reset) begin
         if (state == ST_INIT) begin
            valid_mem[sweep_cnt] <= '0;
            dirty_mem[sweep_cnt] <= '0;
            age_mem[sweep_cnt]   <= init_age;
         end else if (accept) begin
            tag_mem[bus.reqIndex]   <= nxt_tag;
            valid_mem[bus.reqIndex] <= nxt_valid;
            dirty_mem[bus.reqIndex] <= nxt_dirty;
            age_mem[bus.reqIndex]   <= nxt_age;
         end
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state               <= ST_INIT;
         sweep_cnt           <= '0;
         bus.respValid       <= 1'b0;
         bus.respHit         <= 1'b0;
         bus.respWay         <= '0;
         bus.respVictimValid <= 1'b0;
         bus.respVictimTag   <= '0;
         bus.respDirty       <= 1'b0;
         bus.respMulti       <= 1'b0;
      end else begin
         if (state == ST_INIT) begin
            // Counter wraps back to 0 as the last set is cleared.
            sweep_cnt <= sweep_cnt + 1'b1;
            if (sweep_cnt == indexBits'(sets - 1)) state <= ST_READY;
         end
         bus.respValid <= accept;
         if (accept) begin
            bus.respHit         <= hit;
            bus.respWay         <= sel_way;
            bus.respDirty       <= cur_dirty[sel_way];
            bus.respMulti       <= multi;
            bus.respVictimValid <= fill_miss && cur_valid[victim];
            bus.respVictimTag   <= (fill_miss && cur_valid[victim]) ? cur_tag[victim] : '0;
         end
      end
   end
endmodule
